// File: rtl/umi_initiator_if.sv
// Signal bundle between a local host, the UMI initiator and a UMI device port.
// Valid/ready rule for host_*, uhost_req_* and uhost_resp_*: a transfer happens on
// a rising clk edge where valid and ready are both high; once raised, valid and its
// payload hold until that edge.
interface umi_initiator_if #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int UW = 256
);
  logic          host_valid;
  logic          host_ready;
  logic [7:0]    host_cmd;
  logic [3:0]    host_size;
  logic [19:0]   host_options;
  logic [AW-1:0] host_addr;
  logic [AW-1:0] host_srcaddr;
  logic [DW-1:0] host_wrdata;
  logic [DW-1:0] host_rddata;
  logic          host_rdvalid;
  logic          host_error;
  logic [7:0]    stray_count;
  logic          uhost_req_valid;
  logic [UW-1:0] uhost_req_packet;
  logic          uhost_req_ready;
  logic          uhost_resp_valid;
  logic [UW-1:0] uhost_resp_packet;
  logic          uhost_resp_ready;

  modport master (
    input  host_valid, host_cmd, host_size, host_options, host_addr,
           host_srcaddr, host_wrdata, uhost_req_ready, uhost_resp_valid,
           uhost_resp_packet,
    output host_ready, host_rddata, host_rdvalid, host_error, stray_count,
           uhost_req_valid, uhost_req_packet, uhost_resp_ready
  );

  modport slave (
    output host_valid, host_cmd, host_size, host_options, host_addr,
           host_srcaddr, host_wrdata, uhost_req_ready, uhost_resp_valid,
           uhost_resp_packet,
    input  host_ready, host_rddata, host_rdvalid, host_error, stray_count,
           uhost_req_valid, uhost_req_packet, uhost_resp_ready
  );
endinterface

// File: rtl/umi_initiator.sv
// Host-side UMI initiator: one transaction in flight, posted writes, blocking reads
// with a response timeout, and a saturating counter of responses nobody waited for.
module umi_initiator #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int UW      = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            nreset,
  umi_initiator_if.master bus,
  output logic [1:0]      dbg_state_o
);

  // Packet layout: [7:0] cmd, [11:8] size, [31:12] options, [32] write, [33] burst,
  // [63:34] zero, then dstaddr, srcaddr, and the data field filling the rest (needs DW <= DFW).
  localparam int DLO = 64 + 2 * AW;
  localparam int DFW = UW - DLO;
  localparam bit TMO_EN = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  function automatic logic umi_write(input logic [7:0] cmd);
    return cmd[0];
  endfunction

  function automatic logic [UW-1:0] umi_pack(
    input logic          write,
    input logic [7:0]    cmd,
    input logic [3:0]    size,
    input logic [19:0]   options,
    input logic          burst,
    input logic [AW-1:0] dstaddr,
    input logic [AW-1:0] srcaddr,
    input logic [4*AW-1:0] data
  );
    logic [UW-1:0] p;
    p = '0;
    p[7:0]           = cmd;
    p[11:8]          = size;
    p[31:12]         = options;
    p[32]            = write;
    p[33]            = burst;
    p[64 +: AW]      = dstaddr;
    p[64 + AW +: AW] = srcaddr;
    p[DLO +: DFW]    = data[DFW-1:0];
    return p;
  endfunction

  function automatic logic [DW-1:0] umi_unpack_data(input logic [UW-1:0] p);
    return p[DLO +: DW];
  endfunction

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      cmd_q;
  logic [3:0]      size_q;
  logic [19:0]     options_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   srcaddr_q;
  logic [DW-1:0]   wrdata_q;
  logic            write_q;
  logic [DW-1:0]   rddata_q, rddata_d;
  logic            rdvalid_q, rdvalid_d;
  logic            error_q, error_d;
  logic [7:0]      stray_q, stray_d;
  logic            load;
  logic [4*AW-1:0] wide_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rddata_d  = rddata_q;
    rdvalid_d = 1'b0;
    error_d   = 1'b0;
    stray_d   = stray_q;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.host_valid) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.uhost_req_ready) begin
          state_d = write_q ? S_IDLE : S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response landing on the expiry cycle still completes the read.
        if (bus.uhost_resp_valid) begin
          rddata_d  = umi_unpack_data(bus.uhost_resp_packet);
          rdvalid_d = 1'b1;
          state_d   = S_IDLE;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.uhost_resp_valid && (state_q != S_WAIT) && (stray_q != 8'hFF)) begin
      stray_d = stray_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      size_q    <= '0;
      options_q <= '0;
      addr_q    <= '0;
      srcaddr_q <= '0;
      wrdata_q  <= '0;
      write_q   <= 1'b0;
      rddata_q  <= '0;
      rdvalid_q <= 1'b0;
      error_q   <= 1'b0;
      stray_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rddata_q  <= rddata_d;
      rdvalid_q <= rdvalid_d;
      error_q   <= error_d;
      stray_q   <= stray_d;
      if (load) begin
        cmd_q     <= bus.host_cmd;
        size_q    <= bus.host_size;
        options_q <= bus.host_options;
        addr_q    <= bus.host_addr;
        srcaddr_q <= bus.host_srcaddr;
        wrdata_q  <= bus.host_wrdata;
        write_q   <= umi_write(bus.host_cmd);
      end
    end
  end

  always_comb begin
    wide_data = '0;
    wide_data[DW-1:0] = wrdata_q;
  end

  assign bus.host_ready       = (state_q == S_IDLE);
  assign bus.uhost_req_valid  = (state_q == S_REQ);
  assign bus.uhost_req_packet = umi_pack(write_q, cmd_q, size_q, options_q, 1'b0,
                                         addr_q, srcaddr_q, wide_data);
  assign bus.uhost_resp_ready = 1'b1;
  assign bus.host_rddata      = rddata_q;
  assign bus.host_rdvalid     = rdvalid_q;
  assign bus.host_error       = error_q;
  assign bus.stray_count      = stray_q;
  assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_umi_initiator.sv
// Bench for umi_initiator with TIMEOUT=8: directed scenarios plus a randomized mix
// checked against a transaction-level model of outcomes, stray count and read data.
module tb_umi_initiator;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int UW = 256;
  localparam int TMO = 8;

  logic clk;
  logic nreset;
  logic [1:0] dbg_state;
  int vectors = 0;
  int miscompares = 0;

  int exp_stray = 0;
  logic [DW-1:0] exp_rddata = '0;
  logic [DW-1:0] exp_q[$];
  logic [UW-1:0] exp_pkt;

  umi_initiator_if #(.AW(AW), .DW(DW), .UW(UW)) bus ();

  umi_initiator #(.AW(AW), .DW(DW), .UW(UW), .TIMEOUT(TMO)) dut (
    .clk(clk), .nreset(nreset), .bus(bus), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // reference layout of a request packet, assembled field by field
  function automatic logic [UW-1:0] req_pkt(input bit wr, input logic [7:0] cmd,
      input logic [3:0] size, input logic [19:0] opt, input logic [63:0] dst,
      input logic [63:0] src, input logic [63:0] data);
    return {data, src, dst, 30'd0, 1'b0, wr, opt, size, cmd};
  endfunction

  function automatic logic [UW-1:0] resp_pkt(input logic [63:0] data);
    logic [191:0] junk;
    for (int i = 0; i < 6; i++) junk[i*32 +: 32] = $urandom;
    return {data, junk};
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_host();
    bus.host_cmd     = 8'($urandom);
    bus.host_size    = 4'($urandom);
    bus.host_options = 20'($urandom);
    bus.host_addr    = {$urandom, $urandom};
    bus.host_srcaddr = {$urandom, $urandom};
    bus.host_wrdata  = {$urandom, $urandom};
  endtask

  task automatic start_req(input bit wr, input logic [63:0] addr, input logic [63:0] data);
    logic [7:0] cmd;
    cmd = 8'($urandom);
    cmd[0] = wr;
    bus.host_cmd     = cmd;
    bus.host_size    = 4'($urandom);
    bus.host_options = 20'($urandom);
    bus.host_addr    = addr;
    bus.host_srcaddr = {$urandom, $urandom};
    bus.host_wrdata  = data;
    exp_pkt = req_pkt(wr, cmd, bus.host_size, bus.host_options, addr, bus.host_srcaddr, data);
    bus.host_valid = 1'b1;
    step();
    bus.host_valid = 1'b0;
    scramble_host();
  endtask

  // Holds ready low for bp cycles, then accepts; reports what the request channel showed.
  task automatic hold_req(input int bp, input bit resp_at_hs, output int valid_cycles,
                          output bit pkt_ok, output logic [UW-1:0] last_pkt);
    valid_cycles = 0;
    pkt_ok = 1'b1;
    last_pkt = '0;
    for (int i = 0; i <= bp; i++) begin
      bus.uhost_req_ready = (i == bp);
      if (i == bp && resp_at_hs) begin
        bus.uhost_resp_valid = 1'b1;
        bus.uhost_resp_packet = resp_pkt({$urandom, $urandom});
      end
      if (bus.uhost_req_valid === 1'b1) valid_cycles++;
      if (bus.uhost_req_packet !== exp_pkt) pkt_ok = 1'b0;
      last_pkt = bus.uhost_req_packet;
      step();
    end
    bus.uhost_req_ready = 1'b0;
    bus.uhost_resp_valid = 1'b0;
  endtask

  // Counts WAIT cycles until host_ready returns; drives a response in WAIT cycle resp_cycle.
  task automatic wait_resp(input int resp_cycle, input logic [63:0] data, output int waited);
    waited = 0;
    while (waited < 40) begin
      waited++;
      if (waited == resp_cycle) begin
        bus.uhost_resp_valid = 1'b1;
        bus.uhost_resp_packet = resp_pkt(data);
      end
      step();
      bus.uhost_resp_valid = 1'b0;
      if (bus.host_ready === 1'b1) break;
    end
  endtask

  task automatic send_strays(input int n);
    for (int i = 0; i < n; i++) begin
      bus.uhost_resp_valid = 1'b1;
      bus.uhost_resp_packet = resp_pkt({$urandom, $urandom});
      step();
    end
    bus.uhost_resp_valid = 1'b0;
    exp_stray = sat_add(exp_stray, n);
  endtask

  // scenarios
  task automatic test_reset();
    nreset = 1'b0;
    bus.host_valid = 1'b0;
    bus.uhost_req_ready = 1'b0;
    bus.uhost_resp_valid = 1'b0;
    bus.uhost_resp_packet = '0;
    scramble_host();
    repeat (3) step();
    nreset = 1'b1;
    step();
    vectors++; if (bus.host_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.host_ready); end
    vectors++; if (bus.uhost_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b expected 0", bus.uhost_req_valid); end
    vectors++; if (bus.host_rdvalid !== 1'b0 || bus.host_error !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got rdvalid=%b error=%b expected 0 0", bus.host_rdvalid, bus.host_error); end
    vectors++; if (bus.host_rddata !== 64'd0) begin miscompares++; $display("FAIL reset_rddata: got %h expected 0", bus.host_rddata); end
    vectors++; if (bus.stray_count !== 8'd0) begin miscompares++; $display("FAIL reset_stray: got %0d expected 0", bus.stray_count); end
    vectors++; if (bus.uhost_resp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_resp_ready: got %b expected 1", bus.uhost_resp_ready); end
  endtask

  task automatic test_posted_write();
    int vc; bit ok; logic [UW-1:0] pk;
    start_req(1'b1, 64'h1000, 64'hDEAD_BEEF);
    hold_req(0, 1'b0, vc, ok, pk);
    vectors++; if (vc != 1) begin miscompares++; $display("FAIL write_valid_cycles: got %0d expected 1", vc); end
    vectors++; if (pk[127:64] !== 64'h1000 || pk[255:192] !== 64'hDEAD_BEEF || pk[32] !== 1'b1) begin miscompares++; $display("FAIL write_fields: got dst=%h data=%h wr=%b expected 1000 deadbeef 1", pk[127:64], pk[255:192], pk[32]); end
    vectors++; if (!ok) begin miscompares++; $display("FAIL write_packet: got %h expected %h", pk, exp_pkt); end
    vectors++; if (bus.host_ready !== 1'b1 || bus.uhost_req_valid !== 1'b0) begin miscompares++; $display("FAIL write_done: got ready=%b req_valid=%b expected 1 0", bus.host_ready, bus.uhost_req_valid); end
    vectors++; if (bus.host_rdvalid !== 1'b0) begin miscompares++; $display("FAIL write_no_rdvalid: got %b expected 0", bus.host_rdvalid); end
  endtask

  task automatic test_read_backpressure();
    int vc, w; bit ok; logic [UW-1:0] pk;
    start_req(1'b0, 64'h2000, {$urandom, $urandom});
    hold_req(3, 1'b0, vc, ok, pk);
    vectors++; if (vc != 4 || !ok) begin miscompares++; $display("FAIL bp_stable: got valid_cycles=%0d stable=%b expected 4 1", vc, ok); end
    vectors++; if (pk[32] !== 1'b0 || pk[127:64] !== 64'h2000) begin miscompares++; $display("FAIL bp_fields: got wr=%b dst=%h expected 0 2000", pk[32], pk[127:64]); end
    wait_resp(2, 64'h1234, w);
    exp_rddata = 64'h1234;
    vectors++; if (w != 2) begin miscompares++; $display("FAIL bp_latency: got %0d expected 2", w); end
    vectors++; if (bus.host_rdvalid !== 1'b1 || bus.host_rddata !== exp_rddata) begin miscompares++; $display("FAIL bp_rddata: got rdvalid=%b data=%h expected 1 %h", bus.host_rdvalid, bus.host_rddata, exp_rddata); end
    vectors++; if (bus.host_error !== 1'b0) begin miscompares++; $display("FAIL bp_error: got %b expected 0", bus.host_error); end
    step();
    vectors++; if (bus.host_rdvalid !== 1'b0) begin miscompares++; $display("FAIL bp_pulse_width: got %b expected 0", bus.host_rdvalid); end
  endtask

  task automatic test_req_stray();
    int vc, w; bit ok; logic [UW-1:0] pk; logic [63:0] d;
    d = {$urandom, $urandom};
    start_req(1'b0, 64'h3000, 64'd0);
    hold_req(1, 1'b1, vc, ok, pk);
    exp_stray = sat_add(exp_stray, 1);
    vectors++; if (bus.stray_count !== 8'(exp_stray) || bus.host_ready !== 1'b0) begin miscompares++; $display("FAIL hs_stray: got stray=%0d ready=%b expected %0d 0", bus.stray_count, bus.host_ready, exp_stray); end
    wait_resp(1, d, w);
    exp_rddata = d;
    vectors++; if (w != 1 || bus.host_rdvalid !== 1'b1 || bus.host_rddata !== exp_rddata) begin miscompares++; $display("FAIL hs_followup: got waited=%0d rdvalid=%b data=%h expected 1 1 %h", w, bus.host_rdvalid, bus.host_rddata, exp_rddata); end
  endtask

  task automatic test_timeout();
    int vc, w; bit ok; logic [UW-1:0] pk;
    start_req(1'b0, 64'h4000, 64'd0);
    hold_req(0, 1'b0, vc, ok, pk);
    wait_resp(0, 64'd0, w);
    vectors++; if (w != TMO) begin miscompares++; $display("FAIL tmo_wait_cycles: got %0d expected %0d", w, TMO); end
    vectors++; if (bus.host_error !== 1'b1 || bus.host_rdvalid !== 1'b0 || bus.host_ready !== 1'b1) begin miscompares++; $display("FAIL tmo_pulse: got error=%b rdvalid=%b ready=%b expected 1 0 1", bus.host_error, bus.host_rdvalid, bus.host_ready); end
    vectors++; if (bus.host_rddata !== exp_rddata) begin miscompares++; $display("FAIL tmo_rddata: got %h expected %h", bus.host_rddata, exp_rddata); end
    step();
    vectors++; if (bus.host_error !== 1'b0) begin miscompares++; $display("FAIL tmo_pulse_width: got %b expected 0", bus.host_error); end
    send_strays(1);
    vectors++; if (bus.stray_count !== 8'(exp_stray) || bus.host_rdvalid !== 1'b0) begin miscompares++; $display("FAIL tmo_late_resp: got stray=%0d rdvalid=%b expected %0d 0", bus.stray_count, bus.host_rdvalid, exp_stray); end
  endtask

  task automatic test_race();
    int vc, w; bit ok; logic [UW-1:0] pk; logic [63:0] d;
    d = {$urandom, $urandom};
    start_req(1'b0, 64'h5000, 64'd0);
    hold_req(0, 1'b0, vc, ok, pk);
    wait_resp(TMO, d, w);
    exp_rddata = d;
    vectors++; if (w != TMO || bus.host_rdvalid !== 1'b1 || bus.host_error !== 1'b0) begin miscompares++; $display("FAIL race_outcome: got waited=%0d rdvalid=%b error=%b expected %0d 1 0", w, bus.host_rdvalid, bus.host_error, TMO); end
    vectors++; if (bus.host_rddata !== exp_rddata || bus.stray_count !== 8'(exp_stray)) begin miscompares++; $display("FAIL race_data: got data=%h stray=%0d expected %h %0d", bus.host_rddata, bus.stray_count, exp_rddata, exp_stray); end
    step();
    vectors++; if (bus.host_error !== 1'b0) begin miscompares++; $display("FAIL race_no_late_error: got %b expected 0", bus.host_error); end
  endtask

  task automatic test_stray_saturation();
    send_strays(300);
    vectors++; if (bus.stray_count !== 8'd255) begin miscompares++; $display("FAIL sat_count: got %0d expected 255", bus.stray_count); end
    vectors++; if (bus.host_rddata !== exp_rddata || bus.host_rdvalid !== 1'b0) begin miscompares++; $display("FAIL sat_rddata: got data=%h rdvalid=%b expected %h 0", bus.host_rddata, bus.host_rdvalid, exp_rddata); end
  endtask

  task automatic test_reset_mid_read();
    int vc, w; bit ok; logic [UW-1:0] pk; logic [63:0] d;
    start_req(1'b0, 64'h6000, 64'd0);
    hold_req(0, 1'b0, vc, ok, pk);
    repeat (3) step();
    nreset = 1'b0;
    #1;
    exp_stray = 0;
    exp_rddata = '0;
    vectors++; if (bus.host_ready !== 1'b1 || bus.uhost_req_valid !== 1'b0 || dbg_state !== 2'd0) begin miscompares++; $display("FAIL rst_mid_state: got ready=%b req_valid=%b state=%0d expected 1 0 0", bus.host_ready, bus.uhost_req_valid, dbg_state); end
    vectors++; if (bus.host_rddata !== 64'd0 || bus.stray_count !== 8'd0 || bus.host_rdvalid !== 1'b0 || bus.host_error !== 1'b0) begin miscompares++; $display("FAIL rst_mid_outputs: got data=%h stray=%0d rdvalid=%b error=%b expected 0 0 0 0", bus.host_rddata, bus.stray_count, bus.host_rdvalid, bus.host_error); end
    step();
    nreset = 1'b1;
    step();
    vectors++; if (bus.host_rdvalid !== 1'b0 || bus.host_error !== 1'b0) begin miscompares++; $display("FAIL rst_mid_no_pulse: got rdvalid=%b error=%b expected 0 0", bus.host_rdvalid, bus.host_error); end
    send_strays(1);
    vectors++; if (bus.stray_count !== 8'(exp_stray)) begin miscompares++; $display("FAIL rst_mid_late_resp: got %0d expected %0d", bus.stray_count, exp_stray); end
    d = {$urandom, $urandom};
    start_req(1'b0, 64'h7000, 64'd0);
    hold_req(0, 1'b0, vc, ok, pk);
    wait_resp(3, d, w);
    exp_rddata = d;
    vectors++; if (w != 3 || bus.host_rdvalid !== 1'b1 || bus.host_rddata !== exp_rddata) begin miscompares++; $display("FAIL rst_mid_next_read: got waited=%0d rdvalid=%b data=%h expected 3 1 %h", w, bus.host_rdvalid, bus.host_rddata, exp_rddata); end
  endtask

  task automatic test_random();
    int vc, w, bp, rc; bit ok, wr; logic [UW-1:0] pk; logic [63:0] a, d, got;
    for (int it = 0; it < 30; it++) begin
      send_strays(int'($urandom_range(0, 2)));
      wr = 1'($urandom);
      bp = int'($urandom_range(0, 10));
      a  = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      start_req(wr, a, wr ? d : {$urandom, $urandom});
      hold_req(bp, 1'b0, vc, ok, pk);
      vectors++; if (vc != bp + 1 || !ok) begin miscompares++; $display("FAIL rnd_req it=%0d: got valid_cycles=%0d stable=%b expected %0d 1", it, vc, ok, bp + 1); end
      if (wr) begin
        vectors++; if (bus.host_ready !== 1'b1 || bus.host_rdvalid !== 1'b0) begin miscompares++; $display("FAIL rnd_write it=%0d: got ready=%b rdvalid=%b expected 1 0", it, bus.host_ready, bus.host_rdvalid); end
      end else begin
        rc = int'($urandom_range(0, TMO + 2));
        wait_resp(rc, d, w);
        if (rc >= 1 && rc <= TMO) begin
          exp_q.push_back(d);
          vectors++; if (w != rc || bus.host_rdvalid !== 1'b1 || bus.host_error !== 1'b0) begin miscompares++; $display("FAIL rnd_read it=%0d: got waited=%0d rdvalid=%b error=%b expected %0d 1 0", it, w, bus.host_rdvalid, bus.host_error, rc); end
        end else begin
          vectors++; if (w != TMO || bus.host_error !== 1'b1 || bus.host_rdvalid !== 1'b0) begin miscompares++; $display("FAIL rnd_timeout it=%0d: got waited=%0d error=%b rdvalid=%b expected %0d 1 0", it, w, bus.host_error, bus.host_rdvalid, TMO); end
        end
        if (bus.host_rdvalid === 1'b1) begin
          got = bus.host_rddata;
          exp_rddata = (exp_q.size() > 0) ? exp_q.pop_front() : exp_rddata;
          vectors++; if (got !== exp_rddata) begin miscompares++; $display("FAIL rnd_rddata it=%0d: got %h expected %h", it, got, exp_rddata); end
        end else begin
          vectors++; if (bus.host_rddata !== exp_rddata) begin miscompares++; $display("FAIL rnd_rddata_hold it=%0d: got %h expected %h", it, bus.host_rddata, exp_rddata); end
        end
      end
      vectors++; if (bus.stray_count !== 8'(exp_stray)) begin miscompares++; $display("FAIL rnd_stray it=%0d: got %0d expected %0d", it, bus.stray_count, exp_stray); end
      step();
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_queue: got %0d pending reads expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_posted_write();
    test_read_backpressure();
    test_req_stray();
    test_timeout();
    test_race();
    test_stray_saturation();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
